// File: rtl/blake2_pkg.sv
// Shared constants and types for the iterative BLAKE2 G mixing unit.
// Covers both BLAKE2b (64-bit words) and BLAKE2s (32-bit words).
package blake2_pkg;

    // BLAKE2b rotation amounts
    localparam int unsigned RotB1 = 32;
    localparam int unsigned RotB2 = 24;
    localparam int unsigned RotB3 = 16;
    localparam int unsigned RotB4 = 63;

    // BLAKE2s rotation amounts
    localparam int unsigned RotS1 = 16;
    localparam int unsigned RotS2 = 12;
    localparam int unsigned RotS3 = 8;
    localparam int unsigned RotS4 = 7;

    localparam int unsigned WidthS = 32;
    localparam int unsigned WidthB = 64;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StHalf2 = 2'b01,
        StDone  = 2'b10
    } g_state_e;

    function automatic bit width_legal(input int unsigned w);
        return (w == WidthS) || (w == WidthB);
    endfunction

endpackage

// File: rtl/blake2_g_half.sv
// Combinational half of the BLAKE2 G function: add3, xor-rotate, add, xor-rotate.
module blake2_g_half #(
    parameter int unsigned W  = 32,
    parameter int unsigned RA = 16,
    parameter int unsigned RB = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic [W-1:0] m,
    output logic [W-1:0] a_mix,
    output logic [W-1:0] b_mix,
    output logic [W-1:0] c_mix,
    output logic [W-1:0] d_mix
);

    logic [W-1:0] d_xor;
    logic [W-1:0] b_xor;

    always_comb begin
        a_mix = a + b + m;
        d_xor = d ^ a_mix;
        d_mix = (d_xor >> RA) | (d_xor << (W - RA));
        c_mix = c + d_mix;
        b_xor = b ^ c_mix;
        b_mix = (b_xor >> RB) | (b_xor << (W - RB));
    end

endmodule

// File: rtl/blake2_g_iter.sv
// Two-cycle BLAKE2 G unit: half 1 on the accepted inputs, half 2 on the registered
// intermediate, with valid/ready handshakes upstream and downstream.
module blake2_g_iter
    import blake2_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned R1 = (W == WidthB) ? RotB1 : RotS1,
    parameter int unsigned R2 = (W == WidthB) ? RotB2 : RotS2,
    parameter int unsigned R3 = (W == WidthB) ? RotB3 : RotS3,
    parameter int unsigned R4 = (W == WidthB) ? RotB4 : RotS4
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    input  logic [W-1:0] d_i,
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o,
    output logic [W-1:0] c_o,
    output logic [W-1:0] d_o
);

    if (!width_legal(W)) begin : g_bad_width
        $error("blake2_g_iter: W must be 32 or 64");
    end

    g_state_e state_q, state_d;
    logic     load_h1;
    logic     load_out;

    logic [W-1:0] h1_a, h1_b, h1_c, h1_d;
    logic [W-1:0] h2_a, h2_b, h2_c, h2_d;
    logic [W-1:0] mid_a_q, mid_b_q, mid_c_q, mid_d_q, y_q;

    blake2_g_half #(
        .W  (W),
        .RA (R1),
        .RB (R2)
    ) u_half1 (
        .a     (a_i),
        .b     (b_i),
        .c     (c_i),
        .d     (d_i),
        .m     (x_i),
        .a_mix (h1_a),
        .b_mix (h1_b),
        .c_mix (h1_c),
        .d_mix (h1_d)
    );

    blake2_g_half #(
        .W  (W),
        .RA (R3),
        .RB (R4)
    ) u_half2 (
        .a     (mid_a_q),
        .b     (mid_b_q),
        .c     (mid_c_q),
        .d     (mid_d_q),
        .m     (y_q),
        .a_mix (h2_a),
        .b_mix (h2_b),
        .c_mix (h2_c),
        .d_mix (h2_d)
    );

    always_comb begin
        state_d  = state_q;
        load_h1  = 1'b0;
        load_out = 1'b0;
        ready_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    load_h1 = 1'b1;
                    state_d = StHalf2;
                end
            end
            StHalf2: begin
                load_out = 1'b1;
                state_d  = StDone;
            end
            StDone: begin
                if (ready_i) begin
                    ready_o = 1'b1;
                    if (valid_i) begin
                        load_h1 = 1'b1;
                        state_d = StHalf2;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Upstream must never see a handshake complete while reset is held.
        if (!nreset) begin
            ready_o = 1'b0;
        end
    end

    assign valid_o = (state_q == StDone);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= StIdle;
            mid_a_q <= '0;
            mid_b_q <= '0;
            mid_c_q <= '0;
            mid_d_q <= '0;
            y_q     <= '0;
            a_o     <= '0;
            b_o     <= '0;
            c_o     <= '0;
            d_o     <= '0;
        end else begin
            state_q <= state_d;
            if (load_h1) begin
                mid_a_q <= h1_a;
                mid_b_q <= h1_b;
                mid_c_q <= h1_c;
                mid_d_q <= h1_d;
                y_q     <= y_i;
            end
            if (load_out) begin
                a_o <= h2_a;
                b_o <= h2_b;
                c_o <= h2_c;
                d_o <= h2_d;
            end
        end
    end

endmodule
